fdiv_seq: RTL

//  Iterative IEEE-754-style floating-point divider r = a / b, the inverse operation of the

---
 rtl/fdiv_seq_pkg.sv | 20 ++
 rtl/fdiv_seq_if.sv | 26 ++
 rtl/fdiv_seq_mant_core.sv | 44 ++++
 rtl/fdiv_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fdiv_seq_pkg.sv
// Shared definitions for the sequential FP divider: flag positions, FSM encoding, bias.
package fdiv_seq_pkg;

    localparam int FLAG_W       = 5;
    localparam int FLAG_INVALID = 4;
    localparam int FLAG_DIVZERO = 3;
    localparam int FLAG_OVF     = 2;
    localparam int FLAG_UNF     = 1;
    localparam int FLAG_INEXACT = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DIV   = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fdiv_seq_if.sv
// Request/result bundle of the divider. start is a launch strobe, taken only while busy=0;
// done is a single-cycle strobe marking r/flags valid, and they hold until the next done.
interface fdiv_seq_if #(parameter int width = 32);
    import fdiv_seq_pkg::*;

    logic              start;
    logic [width-1:0]  a;
    logic [width-1:0]  b;
    logic              round_mode;
    logic              busy;
    logic              done;
    logic [width-1:0]  r;
    logic [FLAG_W-1:0] flags;
    logic [1:0]        state;

    modport master (
        output start, a, b, round_mode,
        input  busy, done, r, flags, state
    );

    modport slave (
        input  start, a, b, round_mode,
        output busy, done, r, flags, state
    );

endinterface

// File: rtl/fdiv_seq_mant_core.sv
// Restoring mantissa divider: one quotient bit per step, quotient holds n+2 bits after the
// integer bit so the caller gets guard/round/sticky material.
module fdiv_seq_mant_core #(
    parameter int n = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic [n+2:0] quotient,
    output logic         rem_nz
);

    // Partial remainder stays below twice the divisor, so one extra bit suffices.
    logic [n:0]   rem;
    logic [n-1:0] dvs;
    logic [n+2:0] q;
    logic [n:0]   diff;
    logic         ge;

    assign diff = rem - {1'b0, dvs};
    assign ge   = (rem >= {1'b0, dvs});

    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
            dvs <= '0;
            q   <= '0;
        end else if (load) begin
            rem <= {1'b0, dividend};
            dvs <= divisor;
            q   <= '0;
        end else if (step) begin
            q   <= {q[n+1:0], ge};
            rem <= ge ? {diff[n-1:0], 1'b0} : {rem[n-1:0], 1'b0};
        end
    end

    assign quotient = q;
    assign rem_nz   = |rem;

endmodule

// File: rtl/fdiv_seq.sv
// Iterative floating-point divider r = a / b: special-case bypass, one quotient bit per
// clock, then a single normalise/round cycle before the done strobe.
module fdiv_seq
    import fdiv_seq_pkg::*;
#(
    parameter int exp  = 8,
    parameter int frac = 23
) (
    input  logic        clk,
    input  logic        rst,
    fdiv_seq_if.slave   bus
);

    localparam int width = exp + frac + 1;
    localparam int EW    = exp + 2;
    localparam int CW    = $clog2(frac + 4);

    localparam logic signed [EW-1:0] BIAS_E  = EW'(bias(exp));
    localparam logic signed [EW-1:0] ONE_E   = EW'(1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << exp) - 1);
    localparam logic [CW-1:0]        LAST    = CW'(frac + 3);

    localparam logic [width-1:0] QNAN    = {1'b0, {exp{1'b1}}, 1'b1, {(frac-1){1'b0}}};
    localparam logic [width-2:0] INF_MAG = {{exp{1'b1}}, {frac{1'b0}}};

    logic              sign_a, sign_b, sign_r;
    logic [exp-1:0]    ea, eb;
    logic [frac-1:0]   fa, fb;
    logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

    assign sign_a = bus.a[width-1];
    assign sign_b = bus.b[width-1];
    assign ea     = bus.a[width-2:frac];
    assign eb     = bus.b[width-2:frac];
    assign fa     = bus.a[frac-1:0];
    assign fb     = bus.b[frac-1:0];
    assign sign_r = sign_a ^ sign_b;

    // Zero exponent flushes denormals to zero regardless of fraction.
    assign nan_a  = (&ea) && (|fa);
    assign nan_b  = (&eb) && (|fb);
    assign inf_a  = (&ea) && !(|fa);
    assign inf_b  = (&eb) && !(|fb);
    assign zero_a = (ea == '0);
    assign zero_b = (eb == '0);

    logic              spec_hit;
    logic [width-1:0]  spec_r;
    logic [FLAG_W-1:0] spec_flags;

    always_comb begin
        spec_hit   = 1'b1;
        spec_r     = '0;
        spec_flags = '0;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            spec_r                   = QNAN;
            spec_flags[FLAG_INVALID] = 1'b1;
        end else if (inf_a) begin
            spec_r = {sign_r, INF_MAG};
        end else if (zero_b) begin
            spec_r                   = {sign_r, INF_MAG};
            spec_flags[FLAG_DIVZERO] = 1'b1;
        end else if (zero_a || inf_b) begin
            spec_r = {sign_r, {(width-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    logic signed [EW-1:0] exp_diff;
    assign exp_diff = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_E;

    logic [1:0]           state;
    logic [CW-1:0]        count;
    logic                 accept;
    logic                 sign_q;
    logic                 rm_q;
    logic signed [EW-1:0] exp_q;
    logic [width-1:0]     r_q;
    logic [FLAG_W-1:0]    flags_q;

    assign accept = bus.start && ((state == ST_IDLE) || (state == ST_DONE));

    logic [frac+3:0] q;
    logic            rem_nz;

    fdiv_seq_mant_core #(.n(frac + 1)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && !spec_hit),
        .step     (state == ST_DIV),
        .dividend ({1'b1, fa}),
        .divisor  ({1'b1, fb}),
        .quotient (q),
        .rem_nz   (rem_nz)
    );

    logic [frac+3:0]      qn;
    logic signed [EW-1:0] exp_n, exp_f;
    logic [frac:0]        mant;
    logic                 g_bit, r_bit, s_bit, inc;
    logic [frac+1:0]      mant_r;
    logic [width-1:0]     norm_r;
    logic [FLAG_W-1:0]    norm_flags;

    always_comb begin
        qn     = q[frac+3] ? q : {q[frac+2:0], 1'b0};
        exp_n  = q[frac+3] ? exp_q : (exp_q - ONE_E);
        mant   = qn[frac+3:3];
        g_bit  = qn[2];
        r_bit  = qn[1];
        s_bit  = qn[0] | rem_nz;
        inc    = rm_q & g_bit & (r_bit | s_bit | qn[3]);
        mant_r = {1'b0, mant} + {{(frac+1){1'b0}}, inc};
        // A carry out of the mantissa leaves the fraction bits all zero already.
        exp_f  = mant_r[frac+1] ? (exp_n + ONE_E) : exp_n;

        norm_flags               = '0;
        norm_flags[FLAG_INEXACT] = g_bit | r_bit | s_bit;
        if (exp_f >= EXP_MAX) begin
            norm_r                   = {sign_q, INF_MAG};
            norm_flags[FLAG_OVF]     = 1'b1;
            norm_flags[FLAG_INEXACT] = 1'b1;
        end else if (exp_f[EW-1] || (exp_f == '0)) begin
            norm_r                   = {sign_q, {(width-1){1'b0}}};
            norm_flags[FLAG_UNF]     = 1'b1;
            norm_flags[FLAG_INEXACT] = 1'b1;
        end else begin
            norm_r = {sign_q, exp_f[exp-1:0], mant_r[frac-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            sign_q  <= 1'b0;
            rm_q    <= 1'b0;
            exp_q   <= '0;
            r_q     <= '0;
            flags_q <= '0;
        end else if (accept) begin
            sign_q <= sign_r;
            rm_q   <= bus.round_mode;
            exp_q  <= exp_diff;
            count  <= '0;
            if (spec_hit) begin
                state   <= ST_DONE;
                r_q     <= spec_r;
                flags_q <= spec_flags;
            end else begin
                state <= ST_DIV;
            end
        end else begin
            case (state)
                ST_DIV: begin
                    if (count == LAST) state <= ST_ROUND;
                    count <= count + 1'b1;
                end
                ST_ROUND: begin
                    state   <= ST_DONE;
                    r_q     <= norm_r;
                    flags_q <= norm_flags;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy  = (state == ST_DIV) || (state == ST_ROUND);
    assign bus.done  = (state == ST_DONE);
    assign bus.r     = r_q;
    assign bus.flags = flags_q;
    assign bus.state = state;

endmodule
